// File: rtl/dsm_decim.sv
// Third-order CIC decimator for a ternary delta-sigma bitstream with a buffered, overrun-flagged output.
// Optional build macro DSM_DECIM_ROUND_EN: round half up before the output shift instead of truncating.
module dsm_decim #(
    parameter int LOG2_DECIM = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pwm,
    input  logic        pwm_valid,
    output logic [14:0] dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovr,
    input  logic        ovr_clr
);

    localparam int W = 3 * LOG2_DECIM + 2;
    localparam int S = 3 * LOG2_DECIM - 14;
    localparam logic [LOG2_DECIM-1:0] CNT_LAST = {LOG2_DECIM{1'b1}};
    localparam logic [LOG2_DECIM-1:0] CNT_ONE  = {{(LOG2_DECIM-1){1'b0}}, 1'b1};
    localparam logic signed [W:0]     SAT_HI   = (W+1)'(16383);
    localparam logic signed [W:0]     SAT_LO   = ~SAT_HI;

    logic [W-1:0]          w_sym;
    logic [W-1:0]          w_int1;
    logic [W-1:0]          w_int2;
    logic [W-1:0]          w_int3;
    logic [W-1:0]          w_c1;
    logic [W-1:0]          w_c2;
    logic [W-1:0]          w_c3;
    logic                  w_tick;
    logic signed [W:0]     w_ext;
    logic signed [W:0]     w_rnd;
    logic signed [W:0]     w_shr;
    logic [14:0]           w_sat;

    logic [W-1:0]          r_int1;
    logic [W-1:0]          r_int2;
    logic [W-1:0]          r_int3;
    logic [LOG2_DECIM-1:0] r_cnt;
    logic [W-1:0]          r_cap;
    logic                  r_capValid;
    logic [W-1:0]          r_dly1;
    logic [W-1:0]          r_dly2;
    logic [W-1:0]          r_dly3;
    logic [W-1:0]          r_comb;
    logic                  r_combValid;
    logic [14:0]           r_dout;
    logic                  r_outValid;
    logic                  r_ovr;

    // Code 2'b11 is illegal on the modulator side and contributes nothing.
    always_comb begin
        w_sym = '0;
        case (pwm)
            2'b10:   w_sym = {{(W-1){1'b0}}, 1'b1};
            2'b00:   w_sym = '1;
            default: w_sym = '0;
        endcase
    end

    assign w_int1 = r_int1 + w_sym;
    assign w_int2 = r_int2 + w_int1;
    assign w_int3 = r_int3 + w_int2;
    assign w_tick = pwm_valid && (r_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_int1     <= '0;
            r_int2     <= '0;
            r_int3     <= '0;
            r_cnt      <= '0;
            r_cap      <= '0;
            r_capValid <= 1'b0;
        end else begin
            r_capValid <= w_tick;
            if (pwm_valid) begin
                r_int1 <= w_int1;
                r_int2 <= w_int2;
                r_int3 <= w_int3;
                r_cnt  <= r_cnt + CNT_ONE;
            end
            if (w_tick) begin
                r_cap <= w_int3;
            end
        end
    end

    // All three comb sections resolve in one clock; their delay lines only move on a captured frame.
    assign w_c1 = r_cap - r_dly1;
    assign w_c2 = w_c1 - r_dly2;
    assign w_c3 = w_c2 - r_dly3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dly1      <= '0;
            r_dly2      <= '0;
            r_dly3      <= '0;
            r_comb      <= '0;
            r_combValid <= 1'b0;
        end else begin
            r_combValid <= r_capValid;
            if (r_capValid) begin
                r_dly1 <= r_cap;
                r_dly2 <= w_c1;
                r_dly3 <= w_c2;
                r_comb <= w_c3;
            end
        end
    end

    assign w_ext = $signed({r_comb[W-1], r_comb});

`ifdef DSM_DECIM_ROUND_EN
    localparam logic signed [W:0] RND_HALF = (W+1)'(2 ** (S - 1));
    assign w_rnd = w_ext + RND_HALF;
`else
    assign w_rnd = w_ext;
`endif

    assign w_shr = w_rnd >>> S;

    always_comb begin
        w_sat = w_shr[14:0];
        if (w_shr > SAT_HI) begin
            w_sat = 15'h3FFF;
        end else if (w_shr < SAT_LO) begin
            w_sat = 15'h4000;
        end
    end

    // A load always wins over a consume; overrun only when the old sample was never taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dout     <= '0;
            r_outValid <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (r_combValid) begin
                r_dout     <= w_sat;
                r_outValid <= 1'b1;
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            if (r_combValid && r_outValid && !out_ready) begin
                r_ovr <= 1'b1;
            end else if (ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_outValid;
    assign ovr       = r_ovr;

endmodule

// File: tb/tb_dsm_decim.sv
// Scoreboard bench for dsm_decim (LOG2_DECIM = 6): expected samples and out_valid rise edges are queued
// by the stimulus and popped by independent monitors.
module tb_dsm_decim;

    typedef struct packed {
        logic              chk;
        logic signed [14:0] val;
    } expEntry_t;

    logic        clock;
    logic        reset;
    logic [1:0]  pwm;
    logic        pwm_valid;
    logic [14:0] dout;
    logic        out_valid;
    logic        out_ready;
    logic        ovr;
    logic        ovr_clr;

    expEntry_t sbq[$];
    int        riseQ[$];
    int        checks = 0;
    int        failures = 0;
    int        edgeCnt = 0;
    int        acceptCnt = 0;
    bit        riseEn = 1'b0;
    logic      prevValid = 1'b0;

    dsm_decim #(.LOG2_DECIM(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .pwm       (pwm),
        .pwm_valid (pwm_valid),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr       (ovr),
        .ovr_clr   (ovr_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edgeCnt++;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Output monitor: consumes a scoreboard entry per handshake and checks the rise timing of out_valid.
    always @(negedge clock) begin
        expEntry_t e;
        int        expEdge;
        if (reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_sample actual=%0d required=none", int'($signed(dout)));
            end else begin
                e = sbq.pop_front();
                if (e.chk) checkOutput("sample", int'($signed(dout)), int'(e.val));
            end
        end
        if (riseEn && reset && out_valid && !prevValid) begin
            if (riseQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rise actual_edge=%0d required=none", edgeCnt);
            end else begin
                expEdge = riseQ.pop_front();
                checkOutput("rise_edge", edgeCnt, expEdge);
            end
        end
        prevValid = out_valid;
    end

    function automatic logic [1:0] symFor(input int mode, input int k);
        case (mode)
            0:       return 2'b10;
            1:       return 2'b00;
            2:       return 2'b01;
            3:       return 2'b11;
            4:       return (k % 2 == 0) ? 2'b10 : 2'b01;
            default: return (k < 256) ? 2'b10 : 2'b00;
        endcase
    endfunction

    task automatic applyStimulus(input int nSym, input int mode, input bit halfRate, input bit trackRise);
        bit tog = 1'b0;
        int got = 0;
        while (got < nSym) begin
            @(posedge clock); #2;
            if (halfRate) begin
                tog = !tog;
                pwm_valid = tog;
            end else begin
                pwm_valid = 1'b1;
            end
            pwm = symFor(mode, acceptCnt);
            if (pwm_valid) begin
                acceptCnt++;
                got++;
                if (trackRise && (acceptCnt % 64 == 0)) riseQ.push_back(edgeCnt + 3);
            end
        end
        @(posedge clock); #2;
        pwm_valid = 1'b0;
    endtask

    task automatic expectSteady(input int total, input int value);
        expEntry_t e;
        for (int i = 0; i < total; i++) begin
            e.chk = (i >= 3);
            e.val = 15'(value);
            sbq.push_back(e);
        end
    endtask

    task automatic checkDrained(input string name);
        repeat (5) @(posedge clock);
        #2;
        checkOutput({name, "_samples_left"}, sbq.size(), 0);
        checkOutput({name, "_rises_left"}, riseQ.size(), 0);
    endtask

    task automatic doReset();
        @(posedge clock); #2;
        reset = 1'b0;
        pwm_valid = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
        acceptCnt = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int modes[5]  = '{0, 1, 2, 3, 4};
        int values[5] = '{16383, -16384, 0, 0, 8192};

        reset = 1'b1;
        pwm = 2'b01;
        pwm_valid = 1'b0;
        out_ready = 1'b1;
        ovr_clr = 1'b0;
        #3 reset = 1'b0;
        #1;
        checkOutput("reset_dout", int'($signed(dout)), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_ovr", int'(ovr), 0);
        @(posedge clock); #2;
        reset = 1'b1;
        acceptCnt = 0;
        riseEn = 1'b1;

        // Constant and alternating symbol streams at full rate.
        for (int m = 0; m < 5; m++) begin
            expectSteady(6, values[m]);
            applyStimulus(384, modes[m], 1'b0, 1'b1);
            checkDrained("pattern");
            checkOutput("pattern_ovr", int'(ovr), 0);
            doReset();
        end

        // Half-rate pwm_valid: ticks every 128 clocks, output still two edges behind each tick.
        expectSteady(5, 16383);
        applyStimulus(320, 0, 1'b1, 1'b1);
        checkDrained("halfrate");
        doReset();

        // Overrun: nothing consumed across seven ticks, newest sample must be the one held.
        riseEn = 1'b0;
        out_ready = 1'b0;
        applyStimulus(448, 5, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        #2;
        checkOutput("overrun_ovr_set", int'(ovr), 1);
        checkOutput("overrun_valid_held", int'(out_valid), 1);
        begin
            expEntry_t e;
            e.chk = 1'b1;
            e.val = 15'h4000;
            sbq.push_back(e);
        end
        out_ready = 1'b1;
        @(posedge clock); #2;
        checkOutput("overrun_consumed", sbq.size(), 0);
        checkOutput("overrun_valid_fall", int'(out_valid), 0);
        checkOutput("overrun_ovr_sticky", int'(ovr), 1);
        ovr_clr = 1'b1;
        @(posedge clock); #2;
        ovr_clr = 1'b0;
        checkOutput("overrun_ovr_clr", int'(ovr), 0);

        // Reset in the middle of a frame, then a clean restart.
        out_ready = 1'b0;
        applyStimulus(384 + 30, 0, 1'b0, 1'b0);
        checkOutput("midreset_pre_ovr", int'(ovr), 1);
        checkOutput("midreset_pre_dout", int'($signed(dout)), 16383);
        reset = 1'b0;
        #1;
        checkOutput("midreset_dout", int'($signed(dout)), 0);
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_ovr", int'(ovr), 0);
        @(posedge clock); #2;
        reset = 1'b1;
        acceptCnt = 0;
        out_ready = 1'b1;
        riseEn = 1'b1;
        expectSteady(4, 16383);
        applyStimulus(256, 0, 1'b0, 1'b1);
        checkDrained("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
